arm_imm_encoder: RTL and testbench
==================================

Name: arm_imm_encoder

Overview:
- Multi-cycle encoder producing the ARM data-processing immediate form of a 32-bit constant.
- Inverse of the Val2 immediate path: given a value V, finds rotate_imm and imm8 such that ROR({24'b0,imm8}, 2*rotate_imm) == V.
- Used by the assembler/test-program loader and the literal-pool decision logic to decide whether a constant fits a MOV/MVN immediate.
- Searches one rotation per cycle over a request/response handshake.

Parameters:
- ENABLE_INV, 1, when 1 each rotation step also tests ~V, for MVN/BIC substitution.
- ROT_STEPS, 16, number of rotation candidates; fixed by the ISA, not to be overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; accepted only when in_ready=1.
- value  in  32  constant to encode; sampled on the accept edge.
- in_ready  out  1  high in IDLE only.
- flush  in  1  synchronous abort of any in-flight request.
- out_valid  out  1  result available; held until consumed.
- out_ready  in  1  consumer accepts the result.
- found  out  1  an encoding exists.
- inverted  out  1  the encoding applies to ~value (MVN form).
- shift_operand  out  12  {rotate_imm[3:0], imm8[7:0]}.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, in_ready=1, out_valid=0, found=0, inverted=0, shift_operand=0, rot counter=0. Reset mid-search or while in DONE discards the request.
- States and transitions:
  - IDLE -> SEARCH on start && in_ready. value is latched into v_q, and r is cleared to 0.
  - SEARCH: each cycle tests candidate r (combinational).
    - Direct hit: ROL(v_q, 2r)[31:8]==0. The result imm8 is ROL(v_q, 2r)[7:0].
    - Inverted hit (ENABLE_INV=1 only): the same test applied to ~v_q.
    - Precedence: the first r with any hit wins. At the same r, a direct hit beats an inverted hit.
    - On a hit at the edge: register found=1, inverted, shift_operand={r,imm8}, out_valid=1, go to DONE.
    - No hit and r==15: register found=0, inverted=0, shift_operand=0, out_valid=1, go to DONE.
    - Otherwise r<=r+1.
  - DONE: outputs are stable and held. On out_valid && out_ready, out_valid<=0 and go to IDLE. in_ready is 1 on the following cycle.
- Latency: with the accept at edge E0, a hit at rotation r makes out_valid high after edge E0+r+1. The worst case and the not-found case give out_valid after E0+16.
- Throughput: at most one request in flight. start is ignored outside IDLE, and no queueing is done.
- flush:
  - Asserted in SEARCH or DONE: next state is IDLE, out_valid<=0, outputs cleared to 0.
  - flush wins over a hit on the same edge, and over out_ready on the same edge.
  - flush in IDLE is a no-op. Simultaneous flush and start in IDLE: flush wins, and the request is not accepted.
- value=0 is a direct hit at r=0 with imm8=0 (found=1, shift_operand=0x000).
- Rotation amount is 2r (mod 32). r is 4-bit and never wraps past 15 within a request.
- All outputs are registers; there is no combinational path from inputs to outputs except none. in_ready is decoded from the state register.

Decomposition:
- Package arm_imm_pkg:
  - state enum {IDLE, SEARCH, DONE}.
  - localparam ROT_STEPS=16.
  - localparam ROT_W=4.
  - typedef shift_operand_t as 12 bits, with fields rotate/imm8.
- Sub-module rot_candidate_check (combinational):
  - Inputs: v[31:0], r[3:0].
  - Outputs: hit, imm8[7:0].
  - Instantiated twice (direct and inverted). The inverted instance is generated only when ENABLE_INV=1; otherwise inverted is tied to 0.

Test Plan:
- value=0x000000FF, out_ready=1 -> after E0+1: found=1, inverted=0, shift_operand=0x0FF; in_ready=1 the next cycle.
- value=0xF000000F -> valid after E0+3: found=1, shift_operand=0x2FF.
- value=0xFF000000 -> valid after E0+5: shift_operand=0x4FF.
- value=0x00000102 -> valid after E0+16: found=0, inverted=0, shift_operand=0x000.
- ENABLE_INV=1, value=0xFFFFFF00 -> after E0+1: found=1, inverted=1, shift_operand=0x0FF. With ENABLE_INV=0, the same value gives found=0 after E0+16.
- Backpressure and abort:
  - Hold out_ready=0 for 5 cycles after 0x000000FF: outputs stable and start ignored; consumed on the first out_ready=1.
  - Separately, send 0x00000102 and assert flush at E0+7: IDLE next cycle, out_valid never rises.
  - Assert rst at E0+3 of a search: all outputs 0 and in_ready=1 after that edge.

Source files
------------

// File: rtl/arm_imm_encoder_pkg.sv
// Shared types and constants for the ARM data-processing immediate encoder.
//   state_e          : controller states (IDLE, SEARCH, DONE)
//   shift_operand_t  : {rotate[3:0], imm8[7:0]} as it appears in the instruction
//   rol32()          : 32-bit rotate-left helper used by the candidate checker
package arm_imm_pkg;

  localparam int ROT_STEPS = 16;  // rotation candidates fixed by the ISA
  localparam int ROT_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_e;

  typedef struct packed {
    logic [ROT_W-1:0] rotate;
    logic [7:0]       imm8;
  } shift_operand_t;

  // Rotating left by 2r undoes the ROR applied when the immediate is expanded.
  function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] amt);
    logic [63:0] dbl;
    dbl = {v, v} << amt;
    return dbl[63:32];
  endfunction

endpackage

// File: rtl/arm_imm_encoder_if.sv
// Request/response bundle between a requester (master) and the encoder (slave).
//   start/value/in_ready        : request handshake, value sampled on accept
//   flush                       : abort of any in-flight request
//   out_valid/out_ready         : response handshake, result held until consumed
//   found/inverted/shift_operand: encoding result
interface arm_imm_encoder_if import arm_imm_pkg::*; ();

  logic           start;
  logic [31:0]    value;
  logic           in_ready;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic           found;
  logic           inverted;
  shift_operand_t shift_operand;

  modport master (
    output start, value, flush, out_ready,
    input  in_ready, out_valid, found, inverted, shift_operand
  );

  modport slave (
    input  start, value, flush, out_ready,
    output in_ready, out_valid, found, inverted, shift_operand
  );

endinterface

// File: rtl/arm_imm_encoder_rot_candidate_check.sv
// Combinational test of one rotation candidate.
//   v    : constant being encoded
//   r    : rotate_imm candidate (rotation amount is 2*r)
//   hit  : v is exactly an 8-bit value rotated right by 2*r
//   imm8 : the 8-bit value that would be encoded for this candidate
module rot_candidate_check import arm_imm_pkg::*; (
  input  logic [31:0]      v,
  input  logic [ROT_W-1:0] r,
  output logic             hit,
  output logic [7:0]       imm8
);

  logic [31:0] rolled;

  assign rolled = rol32(v, {r, 1'b0});
  assign hit    = (rolled[31:8] == 24'd0);
  assign imm8   = rolled[7:0];

endmodule

// File: rtl/arm_imm_encoder.sv
// Multi-cycle encoder for the ARM data-processing immediate form.
// Searches one rotation per cycle for rotate_imm/imm8 such that
// ROR({24'b0, imm8}, 2*rotate_imm) equals the requested constant, optionally
// also trying its complement (MVN/BIC substitution).
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : request/response handshake and result (slave side)
module arm_imm_encoder import arm_imm_pkg::*; #(
  parameter bit ENABLE_INV = 1'b1,
  parameter int ROT_STEPS  = arm_imm_pkg::ROT_STEPS
) (
  input  logic              clk,
  input  logic              rst,
  arm_imm_encoder_if.slave  bus
);

  localparam logic [ROT_W-1:0] LAST_ROT = ROT_W'(ROT_STEPS - 1);

  state_e           state_q, state_d;
  logic [31:0]      v_q, v_d;
  logic [ROT_W-1:0] rot_q, rot_d;
  logic             out_valid_q, out_valid_d;
  logic             found_q, found_d;
  logic             inverted_q, inverted_d;
  shift_operand_t   shift_op_q, shift_op_d;

  logic             dir_hit, inv_hit;
  logic [7:0]       dir_imm8, inv_imm8;

  rot_candidate_check u_direct (
    .v    (v_q),
    .r    (rot_q),
    .hit  (dir_hit),
    .imm8 (dir_imm8)
  );

  generate
    if (ENABLE_INV) begin : g_inv
      rot_candidate_check u_inverted (
        .v    (~v_q),
        .r    (rot_q),
        .hit  (inv_hit),
        .imm8 (inv_imm8)
      );
    end else begin : g_no_inv
      assign inv_hit  = 1'b0;
      assign inv_imm8 = 8'd0;
    end
  endgenerate

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    v_d         = v_q;
    rot_d       = rot_q;
    out_valid_d = out_valid_q;
    found_d     = found_q;
    inverted_d  = inverted_q;
    shift_op_d  = shift_op_q;

    unique case (state_q)
      IDLE: begin
        // flush beats a simultaneous start: the request is dropped.
        if (bus.start && !bus.flush) begin
          state_d = SEARCH;
          v_d     = bus.value;
          rot_d   = '0;
        end
      end

      SEARCH: begin
        if (bus.flush) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          found_d     = 1'b0;
          inverted_d  = 1'b0;
          shift_op_d  = '0;
        end else if (dir_hit) begin
          // Direct form wins over the inverted form at the same rotation.
          state_d     = DONE;
          out_valid_d = 1'b1;
          found_d     = 1'b1;
          inverted_d  = 1'b0;
          shift_op_d  = shift_operand_t'{rotate: rot_q, imm8: dir_imm8};
        end else if (inv_hit) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          found_d     = 1'b1;
          inverted_d  = 1'b1;
          shift_op_d  = shift_operand_t'{rotate: rot_q, imm8: inv_imm8};
        end else if (rot_q == LAST_ROT) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          found_d     = 1'b0;
          inverted_d  = 1'b0;
          shift_op_d  = '0;
        end else begin
          rot_d = rot_q + 1'b1;
        end
      end

      DONE: begin
        if (bus.flush) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          found_d     = 1'b0;
          inverted_d  = 1'b0;
          shift_op_d  = '0;
        end else if (out_valid_q && bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      v_q         <= '0;
      rot_q       <= '0;
      out_valid_q <= 1'b0;
      found_q     <= 1'b0;
      inverted_q  <= 1'b0;
      shift_op_q  <= '0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      rot_q       <= rot_d;
      out_valid_q <= out_valid_d;
      found_q     <= found_d;
      inverted_q  <= inverted_d;
      shift_op_q  <= shift_op_d;
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.out_valid     = out_valid_q;
  assign bus.found         = found_q;
  assign bus.inverted      = inverted_q;
  assign bus.shift_operand = shift_op_q;

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Self-checking bench: one encoder with the inverted search enabled and one
// without, driven with identical requests and checked against a reference
// model that scans rotations with plain shift arithmetic.
module tb_arm_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush, out_ready;
  logic [31:0] value;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  arm_imm_encoder_if if_inv ();
  arm_imm_encoder_if if_dir ();

  assign if_inv.start = start;      assign if_dir.start = start;
  assign if_inv.value = value;      assign if_dir.value = value;
  assign if_inv.flush = flush;      assign if_dir.flush = flush;
  assign if_inv.out_ready = out_ready;
  assign if_dir.out_ready = out_ready;

  arm_imm_encoder #(.ENABLE_INV(1'b1)) u_dut_inv (.clk(clk), .rst(rst), .bus(if_inv.slave));
  arm_imm_encoder #(.ENABLE_INV(1'b0)) u_dut_dir (.clk(clk), .rst(rst), .bus(if_dir.slave));

  // Observation word per DUT: {out_valid, found, inverted, in_ready, shift_operand}
  logic [15:0] obs [2];
  assign obs[0] = {if_inv.out_valid, if_inv.found, if_inv.inverted, if_inv.in_ready,
                   if_inv.shift_operand};
  assign obs[1] = {if_dir.out_valid, if_dir.found, if_dir.inverted, if_dir.in_ready,
                   if_dir.shift_operand};

  localparam logic [15:0] OBS_IDLE = 16'h1000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: scan r = 0..15 and rotate V left by 2r with plain 64-bit shifts;
  // a candidate fits when the rotated value is below 256.
  function automatic void ref_encode(input logic [31:0] v, input bit en_inv,
                                     output bit f, output bit inv,
                                     output logic [11:0] so, output int lat);
    logic [63:0] t;
    logic [31:0] rv;
    f = 0; inv = 0; so = '0; lat = 16;
    for (int r = 0; r < 16; r++) begin
      t  = {32'd0, v} << (2 * r);
      rv = t[31:0] | t[63:32];
      if (rv < 256) begin
        f = 1; so = {4'(r), rv[7:0]}; lat = r + 1; return;
      end
      t  = {32'd0, ~v} << (2 * r);
      rv = t[31:0] | t[63:32];
      if (en_inv && rv < 256) begin
        f = 1; inv = 1; so = {4'(r), rv[7:0]}; lat = r + 1; return;
      end
    end
  endfunction

  // Issue one request with out_ready held high and check both DUTs.
  task automatic run_req(input logic [31:0] v);
    bit          ef [2], ei [2], got [2];
    logic [11:0] es [2];
    int          el [2];
    ref_encode(v, 1'b1, ef[0], ei[0], es[0], el[0]);
    ref_encode(v, 1'b0, ef[1], ei[1], es[1], el[1]);
    got[0] = 0; got[1] = 0;
    @(negedge clk);
    start = 1'b1; value = v; out_ready = 1'b1;
    @(posedge clk);                       // accept edge E0
    @(negedge clk);
    start = 1'b0; value = $urandom;       // value must already be latched
    for (int i = 0; i < 2; i++) check($sformatf("busy%0d", i), 32'(obs[i][12]), 32'd0);
    for (int k = 1; k <= 20 && !(got[0] && got[1]); k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!got[i] && obs[i][15]) begin
          got[i] = 1;
          check($sformatf("found%0d v=%h", i, v), 32'(obs[i][14]), 32'(ef[i]));
          check($sformatf("inv%0d v=%h", i, v),   32'(obs[i][13]), 32'(ei[i]));
          check($sformatf("so%0d v=%h", i, v),    32'(obs[i][11:0]), 32'(es[i]));
          check($sformatf("lat%0d v=%h", i, v),   32'(k), 32'(el[i]));
        end
      end
    end
    for (int i = 0; i < 2; i++)
      if (!got[i]) check($sformatf("timeout%0d v=%h", i, v), 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ready_after%0d", i), 32'(obs[i][12]), 32'd1);
      check($sformatf("valid_after%0d", i), 32'(obs[i][15]), 32'd0);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    rst = 1'b1; start = 1'b0; flush = 1'b0; out_ready = 1'b0; value = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("reset%0d", i), 32'(obs[i]), 32'(OBS_IDLE));
    rst = 1'b0;

    // Directed values, including boundaries: zero, wrap-around, not found, MVN form.
    run_req(32'h0000_00FF);
    run_req(32'hF000_000F);
    run_req(32'hFF00_0000);
    run_req(32'h0000_0102);
    run_req(32'hFFFF_FF00);
    run_req(32'h0000_0000);
    run_req(32'hFFFF_FFFF);
    run_req(32'h0000_03FC);

    // Random: raw values, rotated imm8 values, and complemented rotated values.
    for (int n = 0; n < 45; n++) begin
      v = {24'd0, 8'($urandom)};
      v = (v >> (2 * (n % 16))) | (v << (32 - 2 * (n % 16)));
      unique case (n % 3)
        0: run_req($urandom);
        1: run_req(v);
        default: run_req(~v);
      endcase
    end

    // Backpressure: result held, start ignored, consumed on first out_ready.
    @(negedge clk);
    out_ready = 1'b0; start = 1'b1; value = 32'h0000_00FF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) check($sformatf("hold%0d c%0d", i, c), 32'(obs[i]), 32'h0000_C0FF);
      start = 1'b1; value = $urandom;
    end
    start = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("consumed%0d", i), 32'(obs[i]), 32'h0000_50FF);

    // Flush mid-search at E0+7: out_valid never rises.
    @(negedge clk);
    start = 1'b1; value = 32'h0000_0102;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) check($sformatf("pre_flush%0d k%0d", i, k), 32'(obs[i][15]), 32'd0);
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 2; i++) check($sformatf("flushed%0d", i), 32'(obs[i]), 32'(OBS_IDLE));
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) check($sformatf("post_flush%0d", i), 32'(obs[i][15]), 32'd0);
    end

    // Flush while in DONE clears the held result.
    out_ready = 1'b0; start = 1'b1; value = 32'h0000_00FF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 2; i++) check($sformatf("flush_done%0d", i), 32'(obs[i]), 32'(OBS_IDLE));

    // Flush and start together in IDLE: request refused.
    start = 1'b1; flush = 1'b1; value = 32'h0000_00FF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) check($sformatf("flush_start%0d", i), 32'(obs[i][12]), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("flush_start_idle%0d", i), 32'(obs[i]), 32'(OBS_IDLE));

    // Reset at E0+3 of a search discards the request.
    start = 1'b1; value = 32'h0000_0102;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) check($sformatf("mid_reset%0d", i), 32'(obs[i]), 32'(OBS_IDLE));
    repeat (16) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("mid_reset_idle%0d", i), 32'(obs[i]), 32'(OBS_IDLE));

    // Encoder still works after the reset.
    run_req(32'hF000_000F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
